// File: rtl/operand_entry.sv
// operand_entry: debounced enter key captures SW[3:0] as operand A, then B, and flags the pair valid.
// Optional ENTRY_TIMEOUT_EN aborts a half-entered pair after TIMEOUT_CYCLES idle cycles in WAIT_B.
module operand_entry #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES  = 250000000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       KEY_N,
    input  logic [3:0] SW,
    output logic [3:0] OP_A,
    output logic [3:0] OP_B,
    output logic       OPS_VALID,
    output logic       OPS_STROBE,
    output logic [1:0] STATE
);
    localparam logic [1:0] WAIT_A = 2'b00;
    localparam logic [1:0] WAIT_B = 2'b01;
    localparam logic [1:0] DONE   = 2'b10;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES);

    logic          key_s1_q, key_s2_q;
    logic [3:0]    sw_s1_q, sw_s2_q;
    logic          deb_q, deb_d, deb_prev_q;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          blk_q, blk_d;
    logic [1:0]    vld_q;
    logic [1:0]    state_q, state_d;
    logic [3:0]    op_a_q, op_a_d, op_b_q, op_b_d;
    logic          strobe_q, strobe_d, valid_q, valid_d;
    logic          press, tmo;

`ifdef ENTRY_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] TMAX = IW'(TIMEOUT_CYCLES);
    logic [IW-1:0] idle_q, idle_d;
    always_comb begin
        tmo    = (state_q == WAIT_B) && (idle_q == TMAX);
        idle_d = (state_q == WAIT_B && state_d == WAIT_B) ? idle_q + 1'b1 : '0;
    end
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) idle_q <= '0;
        else          idle_q <= idle_d;
    end
`else
    assign tmo = 1'b0;
`endif

    // A key held through reset stays blocked until the synced key is seen released at the debounced level.
    always_comb begin
        press    = deb_prev_q & ~deb_q & ~blk_q;
        cnt_d    = (key_s2_q == deb_q || cnt_q == DMAX) ? '0 : cnt_q + 1'b1;
        deb_d    = (key_s2_q != deb_q && cnt_q == DMAX) ? key_s2_q : deb_q;
        blk_d    = blk_q & ~(vld_q[1] & deb_q & key_s2_q);
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        case (state_q)
            WAIT_A: if (press) begin
                state_d = WAIT_B;
                op_a_d  = sw_s2_q;
            end
            WAIT_B: if (press) begin
                state_d = DONE;
                op_b_d  = sw_s2_q;
            end else if (tmo) begin
                state_d = WAIT_A;
                op_a_d  = '0;
            end
            DONE: if (press) begin
                state_d = WAIT_B;
                op_a_d  = sw_s2_q;
                op_b_d  = '0;
            end
            default: state_d = WAIT_A;
        endcase
        strobe_d = press && (state_q == WAIT_B);
        valid_d  = (state_d == DONE);
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            key_s1_q   <= 1'b1;
            key_s2_q   <= 1'b1;
            sw_s1_q    <= '1;
            sw_s2_q    <= '1;
            deb_q      <= 1'b1;
            deb_prev_q <= 1'b1;
            cnt_q      <= '0;
            blk_q      <= 1'b1;
            vld_q      <= '0;
            state_q    <= WAIT_A;
            op_a_q     <= '0;
            op_b_q     <= '0;
            strobe_q   <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            key_s1_q   <= KEY_N;
            key_s2_q   <= key_s1_q;
            sw_s1_q    <= SW;
            sw_s2_q    <= sw_s1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            cnt_q      <= cnt_d;
            blk_q      <= blk_d;
            vld_q      <= {vld_q[0], 1'b1};
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            strobe_q   <= strobe_d;
            valid_q    <= valid_d;
        end
    end

    assign OP_A       = op_a_q;
    assign OP_B       = op_b_q;
    assign OPS_VALID  = valid_q;
    assign OPS_STROBE = strobe_q;
    assign STATE      = state_q;
endmodule

// File: tb/tb_operand_entry.sv
// tb_operand_entry: directed + randomized operand entry checked against an event-level model.
module tb_operand_entry;
    localparam int D = 4;
    localparam int T = 20;
    localparam int CAP = D + 4;
`ifdef ENTRY_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       RESET_N = 1'b0;
    logic       KEY_N = 1'b1;
    logic [3:0] SW = 4'h0;
    logic [3:0] OP_A, OP_B;
    logic       OPS_VALID, OPS_STROBE;
    logic [1:0] STATE;

    int checks = 0;
    int errors = 0;
    logic [3:0] m_a = 0, m_b = 0;
    logic [1:0] m_st = 0;
    logic       m_stb = 0;
    int         m_idle = 0;

    operand_entry #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
        .CLOCK_50(clk), .RESET_N(RESET_N), .KEY_N(KEY_N), .SW(SW),
        .OP_A(OP_A), .OP_B(OP_B), .OPS_VALID(OPS_VALID), .OPS_STROBE(OPS_STROBE), .STATE(STATE)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic check_all();
        chk("op_a", 32'(OP_A), 32'(m_a));
        chk("op_b", 32'(OP_B), 32'(m_b));
        chk("state", 32'(STATE), 32'(m_st));
        chk("valid", 32'(OPS_VALID), 32'(m_st == 2'd2));
        chk("strobe", 32'(OPS_STROBE), 32'(m_stb));
    endtask

    task automatic model_rst();
        m_a = 0; m_b = 0; m_st = 0; m_stb = 0; m_idle = 0;
    endtask

    // pe marks the clock edge on which the model expects the press to be captured.
    task automatic step(input bit pe, input logic [3:0] v);
        m_stb = 0;
        if (pe) begin
            case (m_st)
                2'd0: begin m_a = v; m_st = 1; m_idle = 0; end
                2'd1: begin m_b = v; m_st = 2; m_stb = 1; end
                default: begin m_a = v; m_b = 0; m_st = 1; m_idle = 0; end
            endcase
        end else if (TMO && m_st == 2'd1) begin
            if (m_idle == T) begin m_st = 0; m_a = 0; end
            else m_idle++;
        end
    endtask

    task automatic tick(input bit pe, input logic [3:0] v);
        @(posedge clk);
        if (!RESET_N) model_rst();
        else step(pe, v);
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 4'h0);
    endtask

    task automatic press(input logic [3:0] v, input int hold, input int rel);
        SW = v;
        KEY_N = 1'b0;
        for (int i = 1; i <= hold; i++) begin
            tick(i == CAP, v);
            if (i >= CAP) SW = 4'($urandom_range(0, 15));
        end
        KEY_N = 1'b1;
        run(rel);
    endtask

    initial begin
        #1;
        check_all();
        run(3);
        @(negedge clk);
        RESET_N = 1'b1;
        run(4);
        press(4'h3, 10, 10);
        press(4'hC, 10, 10);
        KEY_N = 1'b0; run(3); KEY_N = 1'b1; run(2);
        KEY_N = 1'b0; run(3); KEY_N = 1'b1; run(10);
        press(4'h7, 100, 10);
        while (m_st != 2'd1) press(4'($urandom_range(0, 15)), CAP, 10);
        KEY_N = 1'b0;
        run(3);
        RESET_N = 1'b0;
        #1;
        model_rst();
        check_all();
        run(2);
        RESET_N = 1'b1;
        run(20);
        KEY_N = 1'b1;
        run(10);
        press(4'($urandom_range(0, 15)), 10, 10);
        for (int k = 0; k < 6; k++)
            press(4'($urandom_range(0, 15)), CAP + int'($urandom_range(0, 5)), 10);
        while (m_st != 2'd1) press(4'($urandom_range(0, 15)), CAP, 10);
`ifdef ENTRY_TIMEOUT_EN
        run(30);
        chk("timeout_state", 32'(STATE), 32'd0);
        chk("timeout_op_a", 32'(OP_A), 32'd0);
        while (m_st != 2'd0) press(4'($urandom_range(0, 15)), CAP, 10);
        press(4'($urandom_range(1, 15)), CAP, T + 1 - CAP);
        press(4'($urandom_range(0, 15)), CAP, 0);
        chk("press_wins", 32'(STATE), 32'd2);
        run(10);
`else
        run(1000);
        chk("no_timeout", 32'(STATE), 32'd1);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
